// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types for the instruction fetch sequencer.
//   cXLEN         : data/address width
//   fetch_state_t : fetch FSM states
//   fetch_entry_t : one buffered instruction together with its PC
package inst_fetch_ctrl_pkg;
  localparam int cXLEN = 32;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;

  typedef struct packed {
    logic [cXLEN-1:0] pc;
    logic [cXLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_fifo.sv
// cDEPTH-entry synchronous FIFO of fetch_entry_t.
//   iClk/iRst : clock, synchronous active-low reset
//   push/pop  : write wdata / advance head (ignored when full / empty)
//   clear     : empty the FIFO (wins over push/pop)
//   rdata     : head entry; full/empty/count : occupancy
module inst_fetch_fifo
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int cDEPTH = 4
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  fetch_entry_t          wdata,
  output fetch_entry_t          rdata,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(cDEPTH):0] count
);
  localparam int PW = $clog2(cDEPTH);
  localparam logic [PW:0] cFULL = (PW+1)'(cDEPTH);

  fetch_entry_t    mem_q [cDEPTH];
  fetch_entry_t    mem_d [cDEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic            do_push, do_pop;

  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    // a push into a full FIFO is fine when the head leaves in the same cycle
    do_push  = push && ((cnt_q != cFULL) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      for (int i = 0; i < cDEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (cnt_q == cFULL);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues in-order imem requests, buffers
// returned words with their PC and hands them to the decoder.
//   iClk, iRst                 : clock, synchronous active-low reset
//   oImemReq/oImemAddr/iImemGnt: request handshake to imem
//   iImemValid/iImemData       : in-order imem responses
//   iBranchTkn/iBranchPC       : redirect from execute
//   iStall                     : decoder back-pressure
//   oInst/oCurPC/oInstVld      : instruction to decoder
//   oFlushPipe                 : one-cycle flush after each redirect
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [cXLEN-1:0] cRESETPC = '0,
  parameter int               cDEPTH   = 4,
  parameter int               cMAXOUT  = 3
) (
  input  logic             iClk,
  input  logic             iRst,
  output logic             oImemReq,
  output logic [cXLEN-1:0] oImemAddr,
  input  logic             iImemGnt,
  input  logic             iImemValid,
  input  logic [cXLEN-1:0] iImemData,
  input  logic             iBranchTkn,
  input  logic [cXLEN-1:0] iBranchPC,
  input  logic             iStall,
  output logic [cXLEN-1:0] oInst,
  output logic [cXLEN-1:0] oCurPC,
  output logic             oInstVld,
  output logic             oFlushPipe
);
  localparam int CW = $clog2(cDEPTH) + 1;
  localparam int SW = CW + 2;
  localparam logic [CW-1:0]    cDEPTH_C  = CW'(cDEPTH);
  localparam logic [CW-1:0]    cMAXOUT_C = CW'(cMAXOUT);
  localparam logic [cXLEN-1:0] cINC      = cXLEN'(4);

  fetch_state_t     state_q, state_d;
  logic [cXLEN-1:0] req_pc_q, req_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]    outst_q, outst_d, drop_q, drop_d;
  // Responses still owed for requests issued before the last reset. They
  // arrive ahead of any post-reset response and are silently consumed.
  logic [SW-1:0]    stale_q, stale_d, stale_rst;
  logic             flush_q, flush_d;

  logic             req, fire, rsp_stale, rsp_live, rsp_keep, redirect;
  logic [CW-1:0]    outst_nxt;
  logic [CW:0]      in_use;
  logic             push, pop, clear, fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_cnt;
  fetch_entry_t     head, wentry;

  always_comb begin
    in_use    = {1'b0, fifo_cnt} + {1'b0, outst_q};
    req       = (state_q != IDLE) && (outst_q < cMAXOUT_C) &&
                (in_use < {1'b0, cDEPTH_C}) && !fifo_full;
    fire      = req && iImemGnt;
    rsp_stale = iImemValid && (stale_q != '0);
    rsp_live  = iImemValid && (stale_q == '0);
    rsp_keep  = rsp_live && (drop_q == '0);
    outst_nxt = outst_q + CW'(fire) - CW'(rsp_live);
    redirect  = iBranchTkn && (state_q != IDLE);

    req_pc_d  = fire ? req_pc_q + cINC : req_pc_q;
    resp_pc_d = rsp_keep ? resp_pc_q + cINC : resp_pc_q;
    drop_d    = drop_q - CW'(rsp_live && (drop_q != '0));
    outst_d   = outst_nxt;
    stale_d   = stale_q - SW'(rsp_stale);
    stale_rst = stale_d + SW'(outst_nxt);
    flush_d   = 1'b0;
    push      = rsp_keep;
    pop       = !fifo_empty && !iStall;
    clear     = 1'b0;
    wentry    = '{pc: resp_pc_q, inst: iImemData};

    if (redirect) begin
      // everything still in flight (including a same-cycle grant) is stale
      req_pc_d  = iBranchPC;
      resp_pc_d = iBranchPC;
      drop_d    = outst_nxt;
      flush_d   = 1'b1;
      push      = 1'b0;
      pop       = 1'b0;
      clear     = 1'b1;
    end

    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (redirect && drop_d != '0) state_d = DRAIN;
      DRAIN:   if (drop_d == '0) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state_q   <= IDLE;
      req_pc_q  <= cRESETPC;
      resp_pc_q <= cRESETPC;
      outst_q   <= '0;
      drop_q    <= '0;
      flush_q   <= 1'b0;
      stale_q   <= stale_rst;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      flush_q   <= flush_d;
      stale_q   <= stale_d;
    end
  end

  inst_fetch_fifo #(.cDEPTH(cDEPTH)) u_fifo (
    .iClk  (iClk),
    .iRst  (iRst),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .wdata (wentry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign oImemReq   = req;
  assign oImemAddr  = req_pc_q;
  assign oInstVld   = !fifo_empty;
  assign oInst      = fifo_empty ? '0 : head.inst;
  assign oCurPC     = fifo_empty ? '0 : head.pc;
  assign oFlushPipe = flush_q;
endmodule
